// File: rtl/button_conditioner_pkg.sv
// Shared constants and state type for the RDID push-button conditioners.
package button_conditioner_pkg;

    localparam int unsigned CCLK_HZ          = 50_000_000;
    localparam int unsigned DEBOUNCE_DEFAULT = 65536;
    localparam int unsigned HOLD_DEFAULT     = 25_000_000;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } btn_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button in, conditioned level and event pulses out.
interface button_conditioner_if;

    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

endinterface

// File: rtl/button_conditioner_sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push button into a clean level plus press/release/long-press pulses.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = HOLD_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(max_u(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1)
) (
    input  logic                 CCLK,
    input  logic                 reset_n,
    button_conditioner_if.slave  btn
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             btn_sync;
    btn_state_e       state_q,   state_d;
    logic [CNT_W-1:0] dcnt_q,    dcnt_d;
    logic [CNT_W-1:0] hcnt_q,    hcnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             long_q,    long_d;

    sync_2ff u_sync (
        .clk_i  (CCLK),
        .rst_ni (reset_n),
        .d_i    (btn.btn_raw),
        .q_o    (btn_sync)
    );

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_sync) begin
                    state_d = ST_PRESS_CHK;
                    dcnt_d  = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!btn_sync) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_sync) begin
                    state_d = ST_RELEASE_CHK;
                    dcnt_d  = '0;
                end else if (hcnt_q != HOLD_MAX) begin
                    // Saturating at HOLD_MAX makes long_pulse a once-per-press event.
                    hcnt_d = hcnt_q + CNT_W'(1);
                    long_d = (hcnt_q == HOLD_LAST);
                end
            end
            ST_RELEASE_CHK: begin
                if (btn_sync) begin
                    state_d = ST_PRESSED;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    dcnt_d    = '0;
                    hcnt_d    = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign btn.btn_level     = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table plus directed bounce, glitch and reset sequences.
module tb_button_conditioner;

    localparam int unsigned D = 16;
    localparam int unsigned H = 100;

    logic        CCLK    = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned cyc     = 0;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H)
    ) dut (
        .CCLK    (CCLK),
        .reset_n (reset_n),
        .btn     (bif.slave)
    );

    always #10 CCLK = ~CCLK;
    always @(posedge CCLK) cyc <= cyc + 1;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_e;
    typedef struct {
        ev_e         kind;
        int unsigned at;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        int unsigned high;
        int unsigned low;
        bit          press;
        bit          lng;
        bit          rel;
    } row_t;
    row_t rows[8];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_ev(input ev_e k);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: got %s at cycle %0d expected none", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                fails++;
                $display("FAIL pulse_order: got %s at cycle %0d expected %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.at);
            end
        end
    endtask

    task automatic push_ev(input ev_e k, input int unsigned at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    logic prev_edge_pulse = 1'b0;
    always @(negedge CCLK) begin
        if (reset_n) begin
            if (bif.press_pulse)   pop_ev(EV_PRESS);
            if (bif.release_pulse) pop_ev(EV_RELEASE);
            if (bif.long_pulse)    pop_ev(EV_LONG);
            if (bif.press_pulse || bif.release_pulse) begin
                check("pulse_exclusive", {31'd0, bif.press_pulse & bif.release_pulse}, 0);
                check("pulse_not_back_to_back", {31'd0, prev_edge_pulse}, 0);
            end
            prev_edge_pulse = bif.press_pulse | bif.release_pulse;
        end else begin
            prev_edge_pulse = 1'b0;
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge CCLK);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_level"},   {31'd0, bif.btn_level},     0);
        check({tag, "_press"},   {31'd0, bif.press_pulse},   0);
        check({tag, "_release"}, {31'd0, bif.release_pulse}, 0);
        check({tag, "_long"},    {31'd0, bif.long_pulse},    0);
    endtask

    task automatic run_row(input int idx);
        int unsigned k;
        int unsigned f;
        step(1);
        k = cyc;
        bif.btn_raw = 1'b1;
        if (rows[idx].press) push_ev(EV_PRESS, k + D + 3);
        if (rows[idx].lng)   push_ev(EV_LONG,  k + D + 3 + H);
        step(rows[idx].high);
        f = cyc;
        bif.btn_raw = 1'b0;
        if (rows[idx].rel) push_ev(EV_RELEASE, f + D + 3);
        step(rows[idx].low);
        check($sformatf("row%0d_level_after", idx), {31'd0, bif.btn_level}, 0);
        check($sformatf("row%0d_events_drained", idx), exp_q.size(), 0);
    endtask

    initial begin
        int unsigned k;
        int unsigned p;
        int unsigned g;
        int unsigned r;

        // high cycles, low cycles, press?, long?, release?
        rows[0] = '{1,   40, 1'b0, 1'b0, 1'b0};
        rows[1] = '{10,  40, 1'b0, 1'b0, 1'b0};
        rows[2] = '{16,  40, 1'b0, 1'b0, 1'b0};
        rows[3] = '{17,  40, 1'b1, 1'b0, 1'b1};
        rows[4] = '{50,  40, 1'b1, 1'b0, 1'b1};
        rows[5] = '{116, 40, 1'b1, 1'b0, 1'b1};
        rows[6] = '{117, 40, 1'b1, 1'b1, 1'b1};
        rows[7] = '{200, 40, 1'b1, 1'b1, 1'b1};

        bif.btn_raw = 1'b0;
        step(3);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        step(5);
        check_outputs_zero("idle");

        for (int i = 0; i < 8; i++) run_row(i);

        // Sub-cycle bounce, then held high; later sub-cycle bounce, then held low.
        step(1);
        k = cyc;
        for (int i = 0; i < 10; i++) begin
            bif.btn_raw = ~bif.btn_raw;
            #1;
        end
        bif.btn_raw = 1'b1;
        push_ev(EV_PRESS, k + D + 3);
        step(60);
        check("bounce_level_high", {31'd0, bif.btn_level}, 1);
        k = cyc;
        for (int i = 0; i < 8; i++) begin
            bif.btn_raw = ~bif.btn_raw;
            #1;
        end
        bif.btn_raw = 1'b0;
        push_ev(EV_RELEASE, k + D + 3);
        step(40);
        check("bounce_level_low", {31'd0, bif.btn_level}, 0);

        // Cycle-rate bounce: 1-cycle runs keep falling back to IDLE.
        for (int i = 0; i < 10; i++) begin
            step(1);
            bif.btn_raw = ~bif.btn_raw;
        end
        step(1);
        bif.btn_raw = 1'b1;
        k = cyc;
        push_ev(EV_PRESS, k + D + 3);
        step(40);
        bif.btn_raw = 1'b0;
        push_ev(EV_RELEASE, cyc + D + 3);
        step(40);
        check("cycle_bounce_drained", exp_q.size(), 0);

        // Short glitches: high in IDLE, then low in PRESSED (delays long_pulse by 11 cycles).
        bif.btn_raw = 1'b1;
        step(10);
        bif.btn_raw = 1'b0;
        step(30);
        check("glitch_idle_level", {31'd0, bif.btn_level}, 0);
        k = cyc;
        bif.btn_raw = 1'b1;
        p = k + D + 3;
        push_ev(EV_PRESS, p);
        step(D + 3 + 20);
        g = cyc;
        bif.btn_raw = 1'b0;
        step(10);
        bif.btn_raw = 1'b1;
        check("glitch_pressed_level", {31'd0, bif.btn_level}, 1);
        push_ev(EV_LONG, p + H + 11);
        step(H + 20);
        check("glitch_gap", g - p, 20);
        bif.btn_raw = 1'b0;
        push_ev(EV_RELEASE, cyc + D + 3);
        step(40);
        check("glitch_drained", exp_q.size(), 0);

        // Reset while in PRESS_CHK (dcnt=8), then while PRESSED; button held throughout.
        k = cyc;
        bif.btn_raw = 1'b1;
        step(11);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("rst_chk");
        step(3);
        reset_n = 1'b1;
        r = cyc;
        push_ev(EV_PRESS, r + D + 3);
        step(D + 3 + 10);
        check("rst_repress_level", {31'd0, bif.btn_level}, 1);
        #4;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("rst_pressed");
        check("rst_pressed_drained", exp_q.size(), 0);
        step(2);
        reset_n = 1'b1;
        r = cyc;
        push_ev(EV_PRESS, r + D + 3);
        push_ev(EV_LONG,  r + D + 3 + H);
        step(D + 3 + H + 10);
        check("rst_long_level", {31'd0, bif.btn_level}, 1);
        bif.btn_raw = 1'b0;
        push_ev(EV_RELEASE, cyc + D + 3);
        step(40);
        check("rst_final_level", {31'd0, bif.btn_level}, 0);
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
